// File: rtl/exe_md_ctrl_pkg.sv
// exe_md_ctrl_pkg: shared md-class opcodes, FSM state type and opcode helpers
// for the EXE-stage multiply/divide unit.
package exe_md_ctrl_pkg;
    localparam logic [3:0] md_none  = 4'd0;
    localparam logic [3:0] md_mult  = 4'd1;
    localparam logic [3:0] md_multu = 4'd2;
    localparam logic [3:0] md_div   = 4'd3;
    localparam logic [3:0] md_divu  = 4'd4;
    localparam logic [3:0] md_madd  = 4'd5;
    localparam logic [3:0] md_maddu = 4'd6;
    localparam logic [3:0] md_msub  = 4'd7;
    localparam logic [3:0] md_msubu = 4'd8;
    localparam logic [3:0] md_mthi  = 4'd9;
    localparam logic [3:0] md_mtlo  = 4'd10;

    typedef enum logic {IDLE, RUN} md_state_e;

    function automatic logic md_is_div(input logic [3:0] op);
        return op == md_div || op == md_divu;
    endfunction

    // Every opcode from mult through msubu occupies the unit for several cycles.
    function automatic logic md_is_multi(input logic [3:0] op);
        return op >= md_mult && op <= md_msubu;
    endfunction
endpackage

// File: rtl/exe_md_ctrl_calc.sv
// md_calc: combinational 64-bit HI/LO result for every multi-cycle md opcode;
// unknown opcodes and divide-by-zero return the current {hi,lo}.
module md_calc
    import exe_md_ctrl_pkg::*;
(
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);
    logic [63:0] acc, prod_s, prod_u, res;
    logic [31:0] abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u, dvs_u;

    assign acc    = {hi, lo};
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    assign abs_a  = A[31] ? -A : A;
    assign abs_b  = (B == 32'd0) ? 32'd1 : (B[31] ? -B : B);
    assign q_mag  = abs_a / abs_b;
    assign r_mag  = abs_a % abs_b;
    assign q_s    = (A[31] ^ B[31]) ? -q_mag : q_mag;
    assign r_s    = A[31] ? -r_mag : r_mag;
    assign dvs_u  = (B == 32'd0) ? 32'd1 : B;
    assign q_u    = A / dvs_u;
    assign r_u    = A % dvs_u;

    always_comb begin
        res = acc;
        case (md_op)
            md_mult:  res = prod_s;
            md_multu: res = prod_u;
            md_madd:  res = acc + prod_s;
            md_maddu: res = acc + prod_u;
            md_msub:  res = acc - prod_s;
            md_msubu: res = acc - prod_u;
            md_div:   res = (B == 32'd0) ? acc : {r_s, q_s};
            md_divu:  res = (B == 32'd0) ? acc : {r_u, q_u};
            default:  res = acc;
        endcase
    end

    assign res_hi = res[63:32];
    assign res_lo = res[31:0];
endmodule

// File: rtl/exe_md_ctrl.sv
// exe_md_ctrl: sequences multiply/divide latency with a countdown, drives the
// registered busy stall flag and owns the architectural HI/LO registers.
module exe_md_ctrl
    import exe_md_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
    logic [31:0] res_hi, res_lo;
    logic        accept;

    md_calc u_calc (
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign accept = start & ~flush & (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        if (state_q == RUN) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
                hi_d    = phi_q;
                lo_d    = plo_q;
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        end else if (accept) begin
            if (md_op == md_mthi) hi_d = A;
            if (md_op == md_mtlo) lo_d = A;
            if (md_is_multi(md_op)) begin
                phi_d   = res_hi;
                plo_d   = res_lo;
                cnt_d   = md_is_div(md_op) ? DIV_N : MULT_N;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_exe_md_ctrl.sv
// tb_exe_md_ctrl: directed vectors; multi-cycle results are queued at issue and
// checked by a monitor whenever busy falls (commit), along with busy length.
module tb_exe_md_ctrl;
    import exe_md_ctrl_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    logic        clk = 0, reset_n = 0, start = 0, flush = 0;
    logic [3:0]  md_op = md_none;
    logic [31:0] A = 0, B = 0;
    logic        busy;
    logic [31:0] hi, lo;
    exp_t        exp_q[$];
    int          total = 0, bad = 0;

    exe_md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
        .A(A), .B(B), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        start = 1; md_op = op; A = a; B = b; flush = fl;
        @(posedge clk); #1;
        start = 0; md_op = md_none; flush = 0;
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
        exp_t e;
        e.hi = h; e.lo = l; e.n = n;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: a busy 1->0 transition is a commit; compare it with the oldest expectation.
    initial begin
        logic prev = 0;
        int   bcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = 0;
                bcnt = 0;
            end else begin
                if (busy) bcnt++;
                if (prev && !busy) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_commit: got hi=%h lo=%h expected none", hi, lo);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_hi", hi, e.hi);
                        chk("commit_lo", lo, e.lo);
                        chk("busy_len", bcnt, e.n);
                    end
                    bcnt = 0;
                end
                prev = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset_n = 1;
        @(posedge clk); #1;
        // Reset mid-operation: asynchronous clear, nothing commits later.
        issue(md_mult, 32'd3, 32'd4, 0);
        @(posedge clk); #3;
        reset_n = 0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset_n = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("arst_nocommit_lo", lo, 32'd0);
        chk("arst_nocommit_busy", {31'd0, busy}, 32'd0);
        // mult / multu
        push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue(md_mult, 32'hFFFFFFFE, 32'd3, 0);
        wait_idle();
        push(32'h00000002, 32'hFFFFFFFA, 5);
        issue(md_multu, 32'hFFFFFFFE, 32'd3, 0);
        wait_idle();
        // div -7/2
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(md_div, 32'hFFFFFFF9, 32'd2, 0);
        wait_idle();
        // mthi/mtlo then divide by zero
        issue(md_mthi, 32'h11, 32'd0, 0);
        chk("mthi_hi", hi, 32'h11);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(md_mtlo, 32'h22, 32'd0, 0);
        chk("mtlo_lo", lo, 32'h22);
        push(32'h11, 32'h22, 10);
        issue(md_div, 32'd5, 32'd0, 0);
        wait_idle();
        push(32'h0, 32'h80000000, 10);
        issue(md_div, 32'h80000000, 32'hFFFFFFFF, 0);
        wait_idle();
        // accumulate
        issue(md_mthi, 32'h0, 32'd0, 0);
        issue(md_mtlo, 32'hFFFFFFFF, 32'd0, 0);
        push(32'h1, 32'h0, 5);
        issue(md_maddu, 32'd1, 32'd1, 0);
        wait_idle();
        push(32'h0, 32'hFFFFFFFF, 5);
        issue(md_msub, 32'd1, 32'd1, 0);
        wait_idle();
        // start with flush is dropped
        issue(md_mult, 32'd7, 32'd7, 1);
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("flush_start_hi", hi, 32'h0);
        chk("flush_start_lo", lo, 32'hFFFFFFFF);
        // start while busy is ignored
        push(32'h0, 32'h6, 5);
        issue(md_mult, 32'd2, 32'd3, 0);
        issue(md_mthi, 32'hDEAD, 32'd0, 0);
        issue(md_mult, 32'd100, 32'd100, 0);
        wait_idle();
        // flush during busy still commits
        push(32'h0, 32'd20, 5);
        issue(md_multu, 32'd4, 32'd5, 0);
        flush = 1;
        repeat (2) @(posedge clk);
        #1;
        flush = 0;
        wait_idle();
        // back-to-back: start in the first idle cycle
        push(32'd2, 32'd14, 10);
        issue(md_divu, 32'd100, 32'd7, 0);
        wait_idle();
        push(32'h0, 32'h1, 5);
        issue(md_mult, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        push(32'hFFFFFFFF, 32'hFFFFFFFF, 5);
        issue(md_madd, 32'hFFFFFFFF, 32'd2, 0);
        wait_idle();
        // undefined opcode does nothing
        issue(4'hF, 32'd1, 32'd2, 0);
        chk("undef_busy", {31'd0, busy}, 32'd0);
        chk("undef_hi", hi, 32'hFFFFFFFF);
        chk("undef_lo", lo, 32'hFFFFFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
